// File: rtl/inverse_clarke_if.sv
// Handshake and data bundle for the inverse Clarke stage.
// The master drives alpha/beta/start. The slave (the transform) returns
// ready, the three phase results and the done pulse.
interface inverse_clarke_if #(
    parameter int D_WIDTH = 18
);
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic                      start;
    logic                      ready;
    logic signed [D_WIDTH-1:0] a;
    logic signed [D_WIDTH-1:0] b;
    logic signed [D_WIDTH-1:0] c;
    logic                      done;

    modport master (
        output alpha,
        output beta,
        output start,
        input  ready,
        input  a,
        input  b,
        input  c,
        input  done
    );

    modport slave (
        input  alpha,
        input  beta,
        input  start,
        output ready,
        output a,
        output b,
        output c,
        output done
    );
endinterface

// File: rtl/inverse_clarke.sv
// Sequential inverse Clarke transform (alpha, beta) -> (a, b, c), signed fixed point.
//   a = alpha
//   b = -alpha/2 + K*beta
//   c = -alpha/2 - K*beta,  K = round(sqrt(3)/2 * 2^Q_BITS)
// One constant multiply is shared across an IDLE -> MUL -> SUM sequence, so a
// conversion takes three cycles from accept to done.
// Optional macro INVERSE_CLARKE_SAT_EN: clamp b/c to the D_WIDTH signed range
// instead of wrapping them to the low D_WIDTH bits.
module inverse_clarke #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15
) (
    input  logic                clk,
    input  logic                rst,
    inverse_clarke_if.slave     bus
);

    localparam int K_W    = D_WIDTH + Q_BITS;
    localparam int PROD_W = D_WIDTH + K_W;
    localparam int WIDE_W = D_WIDTH + 2;

    // sqrt(3)/2 in Q_BITS fractional bits, rounded to nearest.
    localparam logic signed [K_W-1:0]    SQRT3_DIV_2 =
        K_W'($rtoi(0.8660254 * (2.0 ** Q_BITS) + 0.5));
    localparam logic signed [PROD_W-1:0] K_EXT = PROD_W'(SQRT3_DIV_2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SUM  = 2'd2
    } state_t;

    // Reduce a widened sum back to the port width (clamp or wrap).
    function automatic logic signed [D_WIDTH-1:0] reduce_f(
        input logic signed [WIDE_W-1:0] v
    );
`ifdef INVERSE_CLARKE_SAT_EN
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        max_v = (WIDE_W)'((64'sd1 <<< (D_WIDTH - 1)) - 64'sd1);
        min_v = (WIDE_W)'(-(64'sd1 <<< (D_WIDTH - 1)));
        if (v > max_v) begin
            return D_WIDTH'(max_v);
        end else if (v < min_v) begin
            return D_WIDTH'(min_v);
        end else begin
            return D_WIDTH'(v);
        end
`else
        return D_WIDTH'(v);
`endif
    endfunction

    state_t                    state_r;
    logic signed [D_WIDTH-1:0] alpha_r;
    logic signed [D_WIDTH-1:0] beta_r;
    logic signed [D_WIDTH:0]   p_r;
    logic signed [D_WIDTH-1:0] a_r;
    logic signed [D_WIDTH-1:0] b_r;
    logic signed [D_WIDTH-1:0] c_r;
    logic                      ready_r;
    logic                      done_r;

    logic signed [PROD_W-1:0]  beta_ext_s;
    logic signed [D_WIDTH:0]   p_next_s;
    logic signed [WIDE_W-1:0]  p_ext_s;
    logic signed [WIDE_W-1:0]  h_s;
    logic signed [WIDE_W-1:0]  b_wide_s;
    logic signed [WIDE_W-1:0]  c_wide_s;
    logic signed [D_WIDTH-1:0] b_next_s;
    logic signed [D_WIDTH-1:0] c_next_s;

    // Datapath: scaled beta product (floor shift) and the two half-alpha sums.
    always_comb begin
        beta_ext_s = {{(PROD_W - D_WIDTH){beta_r[D_WIDTH-1]}}, beta_r};
        // Product fits PROD_W exactly; the arithmetic shift floors toward -inf.
        p_next_s   = (D_WIDTH + 1)'((beta_ext_s * K_EXT) >>> Q_BITS);
        p_ext_s    = {p_r[D_WIDTH], p_r};
        h_s        = $signed({{2{alpha_r[D_WIDTH-1]}}, alpha_r}) >>> 1;
        b_wide_s   = p_ext_s - h_s;
        c_wide_s   = -p_ext_s - h_s;
        b_next_s   = reduce_f(b_wide_s);
        c_next_s   = reduce_f(c_wide_s);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            alpha_r <= {D_WIDTH{1'b0}};
            beta_r  <= {D_WIDTH{1'b0}};
            p_r     <= {(D_WIDTH + 1){1'b0}};
            a_r     <= {D_WIDTH{1'b0}};
            b_r     <= {D_WIDTH{1'b0}};
            c_r     <= {D_WIDTH{1'b0}};
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        alpha_r <= bus.alpha;
                        beta_r  <= bus.beta;
                        ready_r <= 1'b0;
                        state_r <= ST_MUL;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    p_r     <= p_next_s;
                    done_r  <= 1'b0;
                    ready_r <= 1'b0;
                    state_r <= ST_SUM;
                end
                ST_SUM: begin
                    a_r     <= alpha_r;
                    b_r     <= b_next_s;
                    c_r     <= c_next_s;
                    done_r  <= 1'b1;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.a     = a_r;
    assign bus.b     = b_r;
    assign bus.c     = c_r;

endmodule

// File: doc/inverse_clarke.md
# inverse_clarke

Sequential inverse Clarke transform: converts a stationary-frame pair (alpha, beta) back into three-phase quantities (a, b, c) in signed fixed point. It sits on the modulation side of the FOC datapath, after the inverse Park stage and ahead of the PWM/SVM generator. It is the counterpart of the forward Clarke stage on the sensing side. A single shared constant multiplier is time-multiplexed under a small FSM with a start/ready/done handshake.

## Interface
Parameters:
- D_WIDTH, 18, width of all data ports, signed two's complement; D_WIDTH = Q_BITS + 3
- Q_BITS, 15, fractional bits of the fixed-point format

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- alpha  input  D_WIDTH  alpha component, sampled on accepted start
- beta  input  D_WIDTH  beta component, sampled on accepted start
- start  input  1  request; accepted only when ready=1
- ready  output  1  high in IDLE; block can accept start
- a  output  D_WIDTH  phase a result, registered
- b  output  D_WIDTH  phase b result, registered
- c  output  D_WIDTH  phase c result, registered
- done  output  1  one-cycle pulse; a/b/c valid from this cycle on

## Operation
- Equations: a = alpha; b = -alpha/2 + K*beta; c = -alpha/2 - K*beta. K = SQRT3_DIV_2 = round(0.8660254 * 2^Q_BITS), which is 28378 for Q15. K is a localparam of width D_WIDTH+Q_BITS.
- FSM states:
  - IDLE: ready=1. On start, capture alpha and beta into internal registers and go to MUL.
  - MUL: p = (beta_r * K) >>> Q_BITS. Full-width product, arithmetic shift (floor). Register p at D_WIDTH+1 bits. Go to SUM.
  - SUM: h = alpha_r >>> 1 (floor). Compute b_w = p - h and c_w = -p - h at D_WIDTH+2 bits, then reduce to D_WIDTH (see Configuration). Register a=alpha_r, b, c. Assert done next cycle. Go to IDLE.
- Outputs a/b/c hold their last result until the next completion.
- start while ready=0 is ignored and not queued.
- Input ports are ignored except in the cycle a start is accepted.

## Timing
- Reset values: a=b=c=0, done=0, ready=1, state=IDLE, internal registers 0.
- Latency: start accepted in cycle 0 -> MUL in cycle 1 -> SUM in cycle 2 -> done=1 with valid a/b/c in cycle 3.
- Throughput: ready=1 again in cycle 3, so a new start can be accepted in the same cycle as done. Maximum rate is one conversion per 3 cycles.
- done is high for exactly one cycle per accepted start. It is never asserted without a preceding accept.
- rst in any state: the next cycle is IDLE with all outputs at reset values. An in-flight conversion is discarded and produces no done.
- rst and start in the same cycle: rst wins and start is not accepted.

## Configuration
- INVERSE_CLARKE_SAT_EN defined: b_w and c_w are clamped to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1] before registering.
- INVERSE_CLARKE_SAT_EN undefined: b_w and c_w are truncated to the low D_WIDTH bits (two's-complement wrap).
- a is never affected by this macro, since it is a pass-through of alpha.

## Test plan
- Reset: assert rst for 2 cycles -> a=b=c=0, done=0, ready=1. Pulse start with no rst -> done exactly 3 cycles later.
- Pure alpha: alpha=16384, beta=0, start in cycle 0 -> cycle 3: done=1, a=16384, b=-8192, c=-8192.
- Pure beta: alpha=0, beta=32767 -> a=0, b=28377, c=-28377.
- Overflow: alpha=-131072, beta=-131072 -> a=-131072, b=-47976. c=131071 with INVERSE_CLARKE_SAT_EN defined; c=-83096 without it.
- Back-to-back and busy: hold start high with inputs changing every cycle -> accepts only in cycles 0, 3, 6. done pulses in cycles 3, 6, 9. Each result uses the inputs present at its accept cycle.
- Reset mid-operation: start in cycle 0, rst in cycle 1 -> no done pulse, outputs 0, ready=1 in cycle 2. A new start then completes normally.
